stopwatch_ctrl: RTL and testbench

Control FSM and centisecond timebase that sequences the stopwatch counting datapath (sec:csec BCD counter). It turns the three debounced button edge pulses into run/pause/lap/clear behaviour and issues one-cycle count-enable ticks, a counter-clear pulse and a display-freeze level. The block sits between the button edge detectors and the counter/display path. It holds no time value itself.

---
 rtl/stopwatch_ctrl.sv | 108 ++++++++++
 tb/tb_stopwatch_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM and centisecond timebase.
// Turns button edge pulses into run/pause/lap/clear and count ticks.
module stopwatch_ctrl #(
  parameter int CLK_PER_CSEC = 1_250_000,
  parameter int PRESC_W      = 21
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic [2:0] btn_pedge,
  input  logic       at_max,
  output logic       csec_tick,
  output logic       cnt_clr,
  output logic       lap_freeze,
  output logic [1:0] state,
  output logic       run_led
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_e;

  localparam logic [PRESC_W-1:0] PMAX =
    PRESC_W'(CLK_PER_CSEC - 1);

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               clr_q, clr_d;
  logic               frz_q;
  logic               running;
  logic               b_clr, b_start, b_lap;

  // one press per cycle: clear > start > lap
  assign b_clr   = btn_pedge[2];
  assign b_start = btn_pedge[0] & ~btn_pedge[2];
  assign b_lap   = btn_pedge[1] & ~btn_pedge[0]
                 & ~btn_pedge[2];

  assign running = (state_q == RUN) || (state_q == LAP);

  // state, prescaler and registered pulse/level outputs
  always_ff @(posedge clk) begin
    if (reset_p) begin
      state_q <= IDLE;
      presc_q <= '0;
      clr_q   <= 1'b0;
      frz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      clr_q   <= clr_d;
      frz_q   <= (state_d == LAP);
    end
  end

  // next-state, prescaler advance and clear decode
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    presc_d = presc_q;
    if (running) begin
      presc_d = (presc_q == PMAX) ? '0 : presc_q + 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (b_clr) begin
          clr_d   = 1'b1;
          presc_d = '0;
        end else if (b_start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (at_max || b_start) begin
          state_d = PAUSE;
        end else if (b_lap) begin
          state_d = LAP;
        end
      end
      LAP: begin
        if (at_max || b_start) begin
          state_d = PAUSE;
        end else if (b_lap) begin
          state_d = RUN;
        end
      end
      PAUSE: begin
        if (b_clr) begin
          clr_d   = 1'b1;
          presc_d = '0;
          state_d = IDLE;
        end else if (b_start && !at_max) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign csec_tick  = running && (presc_q == PMAX) && !at_max;
  assign cnt_clr    = clr_q;
  assign lap_freeze = frz_q;
  assign state      = state_q;
  assign run_led    = running;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl at CLK_PER_CSEC=4.
// Expected values are hand-derived cycle by cycle.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset_p;
  logic [2:0] btn_pedge;
  logic       at_max;
  logic       csec_tick;
  logic       cnt_clr;
  logic       lap_freeze;
  logic [1:0] state;
  logic       run_led;

  int nvec = 0;
  int nerr = 0;

  stopwatch_ctrl #(
    .CLK_PER_CSEC(4),
    .PRESC_W     (2)
  ) dut (
    .clk       (clk),
    .reset_p   (reset_p),
    .btn_pedge (btn_pedge),
    .at_max    (at_max),
    .csec_tick (csec_tick),
    .cnt_clr   (cnt_clr),
    .lap_freeze(lap_freeze),
    .state     (state),
    .run_led   (run_led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [2:0] b);
    btn_pedge = b;
    cyc();
    btn_pedge = 3'b000;
  endtask

  initial begin
    int bad;
    reset_p   = 1'b1;
    btn_pedge = 3'b000;
    at_max    = 1'b0;
    cyc();
    cyc();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_tick", 32'(csec_tick), 32'd0);
    chk("rst_clr", 32'(cnt_clr), 32'd0);
    chk("rst_frz", 32'(lap_freeze), 32'd0);
    chk("rst_led", 32'(run_led), 32'd0);
    reset_p = 1'b0;

    // lap in IDLE is ignored
    press(3'b010);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (state != 2'b00 || csec_tick || lap_freeze) bad++;
      cyc();
    end
    chk("idle_quiet", 32'(bad), 32'd0);

    // start: RUN at cycle 1, ticks at 4, 8, 12
    press(3'b001);
    chk("start_state", 32'(state), 32'd1);
    chk("start_led", 32'(run_led), 32'd1);
    chk("start_tick", 32'(csec_tick), 32'd0);
    for (int k = 2; k <= 13; k++) begin
      cyc();
      chk($sformatf("cad_c%0d", k), 32'(csec_tick),
          32'((k % 4) == 0));
    end

    // pause with presc 1 -> held at 2 in PAUSE
    cyc();
    press(3'b001);
    chk("pause_state", 32'(state), 32'd2);
    chk("pause_led", 32'(run_led), 32'd0);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (csec_tick || state != 2'b10) bad++;
      cyc();
    end
    chk("pause_quiet", 32'(bad), 32'd0);

    // resume: tick 1 cycle after RUN, then every 4
    press(3'b001);
    chk("resume_state", 32'(state), 32'd1);
    chk("resume_t0", 32'(csec_tick), 32'd0);
    cyc();
    chk("resume_t1", 32'(csec_tick), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk($sformatf("resume_r%0d", i), 32'(csec_tick),
          32'(i == 4));
    end

    // lap on a tick cycle: presc 0 in LAP
    press(3'b010);
    chk("lap_state", 32'(state), 32'd3);
    chk("lap_frz", 32'(lap_freeze), 32'd1);
    chk("lap_led", 32'(run_led), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk($sformatf("lap_t%0d", i), 32'(csec_tick),
          32'(i == 3));
    end
    chk("lap_frz_hold", 32'(lap_freeze), 32'd1);
    press(3'b010);
    chk("lap2_state", 32'(state), 32'd1);
    chk("lap2_frz", 32'(lap_freeze), 32'd0);
    press(3'b010);
    chk("lap3_state", 32'(state), 32'd3);
    press(3'b001);
    chk("lapst_state", 32'(state), 32'd2);
    chk("lapst_frz", 32'(lap_freeze), 32'd0);
    chk("lapst_tick", 32'(csec_tick), 32'd0);

    // all buttons in PAUSE: clear wins
    press(3'b111);
    chk("clr_pulse", 32'(cnt_clr), 32'd1);
    chk("clr_state", 32'(state), 32'd0);
    cyc();
    chk("clr_one", 32'(cnt_clr), 32'd0);

    // presc was zeroed: full 4-cycle wait for tick
    press(3'b001);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk($sformatf("clr_t%0d", i), 32'(csec_tick),
          32'(i == 3));
    end
    press(3'b100);
    chk("runclr_state", 32'(state), 32'd1);
    chk("runclr_pulse", 32'(cnt_clr), 32'd0);
    press(3'b011);
    chk("prio_state", 32'(state), 32'd2);

    // overflow: presc 1 held, resume, at_max on tick cycle
    press(3'b001);
    cyc();
    cyc();
    at_max = 1'b1;
    #1;
    chk("max_tick", 32'(csec_tick), 32'd0);
    cyc();
    chk("max_state", 32'(state), 32'd2);
    press(3'b001);
    chk("max_start", 32'(state), 32'd2);
    press(3'b100);
    chk("max_clr", 32'(cnt_clr), 32'd1);
    chk("max_idle", 32'(state), 32'd0);
    at_max = 1'b0;

    // reset mid-count
    press(3'b001);
    press(3'b010);
    reset_p = 1'b1;
    cyc();
    reset_p = 1'b0;
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_frz", 32'(lap_freeze), 32'd0);
    chk("mid_rst_clr", 32'(cnt_clr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
